pipeline_stall_controller: RTL and testbench

- Consumes the RAW-hazard flag from hazard detection, the EXE-stage branch-taken flag and the MEM-stage memory handshake.
- Produces the per-stage freeze and flush controls for the ARM 5-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Contains a memory-wait FSM with timeout, and saturating event counters for debug.

---
 rtl/pipeline_stall_controller_if.sv | 38 +++
 rtl/pipeline_stall_controller.sv | 143 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Pipeline control bundle between the hazard, branch and memory sources and the
// stall controller. The master drives the condition flags and memory handshake.
// The slave (the controller) returns the per-stage freeze/flush controls and
// the debug counters.
interface pipeline_stall_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 hazard;
    logic                 branch_taken;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 mem_start;
    logic                 freeze_if;
    logic                 freeze_id;
    logic                 freeze_exe;
    logic                 flush_ifid;
    logic                 flush_idexe;
    logic                 bubble_wb;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] hazard_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] memwait_cnt;

    modport master (
        output hazard, branch_taken, mem_req, mem_ready,
        input  mem_start, freeze_if, freeze_id, freeze_exe,
               flush_ifid, flush_idexe, bubble_wb, mem_timeout,
               hazard_cnt, flush_cnt, memwait_cnt
    );

    modport slave (
        input  hazard, branch_taken, mem_req, mem_ready,
        output mem_start, freeze_if, freeze_id, freeze_exe,
               flush_ifid, flush_idexe, bubble_wb, mem_timeout,
               hazard_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush controller for the ARM 5-stage pipeline registers.
// A memory stall outranks a taken branch, and a taken branch outranks a RAW
// hazard. A memory-wait FSM launches each multi-cycle access and gives up after
// MEM_TIMEOUT wait cycles. Saturating counters record stall and flush events
// for debug.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    pipeline_stall_controller_if.slave    ctl
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_cnt_next;
    logic                 timeout_flag;
    logic [CNT_WIDTH-1:0] hazard_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] memwait_cnt;

    logic                 in_wait;
    logic                 start_access;
    logic                 timeout_hit;
    logic                 mem_stall;
    logic                 branch_rule;
    logic                 hazard_rule;

    // Counter step that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        result = value;
        if (value != {CNT_WIDTH{1'b1}}) begin
            result = value + CNT_WIDTH'(1);
        end
        return result;
    endfunction

    // Condition decode: all combinational outputs are held low during reset.
    // The cycle that reaches the timeout limit is not a stall, so the freezes
    // drop in that cycle.
    always_comb begin
        in_wait      = 1'b0;
        start_access = 1'b0;
        timeout_hit  = 1'b0;
        mem_stall    = 1'b0;
        branch_rule  = 1'b0;
        hazard_rule  = 1'b0;
        if (!rst) begin
            in_wait      = (state == ST_MEM_WAIT);
            start_access = (state == ST_IDLE) && ctl.mem_req && !ctl.mem_ready;
            timeout_hit  = in_wait && !ctl.mem_ready && (wait_cnt == WAIT_LIMIT);
            mem_stall    = (in_wait && !ctl.mem_ready && !timeout_hit) || start_access;
            branch_rule  = !mem_stall && ctl.branch_taken;
            hazard_rule  = !mem_stall && !ctl.branch_taken && ctl.hazard;
        end
    end

    // Drive the pipeline-register controls from the winning rule.
    // The branch rule squashes the instruction in ID, so it suppresses the hazard.
    always_comb begin
        ctl.mem_start   = start_access;
        ctl.freeze_if   = mem_stall || hazard_rule;
        ctl.freeze_id   = mem_stall;
        ctl.freeze_exe  = mem_stall;
        ctl.flush_ifid  = branch_rule;
        ctl.flush_idexe = branch_rule || hazard_rule;
        ctl.bubble_wb   = mem_stall || timeout_hit;
    end

    // Memory-wait FSM next state: the wait counter loads 1 on launch, then
    // counts each unanswered wait cycle until the data arrives or the limit is hit.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (state == ST_IDLE) begin
            if (start_access) begin
                state_next    = ST_MEM_WAIT;
                wait_cnt_next = WAIT_W'(1);
            end
        end else begin
            if (ctl.mem_ready || timeout_hit) begin
                state_next = ST_IDLE;
            end else begin
                wait_cnt_next = wait_cnt + WAIT_W'(1);
            end
        end
    end

    // FSM state and wait counter. A reset during a wait drops the access
    // without raising the timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Sticky timeout flag: once set, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end
    end

    // Saturating debug counters for hazard bubbles, branch flushes and wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cnt  <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (hazard_rule) begin
                hazard_cnt <= sat_inc(hazard_cnt);
            end
            if (branch_rule) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (in_wait) begin
                memwait_cnt <= sat_inc(memwait_cnt);
            end
        end
    end

    assign ctl.mem_timeout = timeout_flag;
    assign ctl.hazard_cnt  = hazard_cnt;
    assign ctl.flush_cnt   = flush_cnt;
    assign ctl.memwait_cnt = memwait_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller. Two instances share one stimulus:
// one uses the default parameters, and one uses a short timeout with narrow
// counters. A behavioural model is compared every cycle, and directed vectors
// also carry literal expectations.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard = 1'b0;
    logic branch_taken = 1'b0;
    logic mem_req = 1'b0;
    logic mem_ready = 1'b0;
    logic check_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_WIDTH(16)) bus_a ();
    pipeline_stall_controller_if #(.CNT_WIDTH(2))  bus_b ();

    assign bus_a.hazard       = hazard;
    assign bus_a.branch_taken = branch_taken;
    assign bus_a.mem_req      = mem_req;
    assign bus_a.mem_ready    = mem_ready;
    assign bus_b.hazard       = hazard;
    assign bus_b.branch_taken = branch_taken;
    assign bus_b.mem_req      = mem_req;
    assign bus_b.mem_ready    = mem_ready;

    pipeline_stall_controller #(.MEM_TIMEOUT(64), .CNT_WIDTH(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .ctl (bus_a)
    );

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .ctl (bus_b)
    );

    // Control bits in the order {mem_start, freeze_if, freeze_id, freeze_exe,
    // flush_ifid, flush_idexe, bubble_wb, mem_timeout}.
    logic [7:0] ctrl_act [2];
    int         hcnt_act [2];
    int         fcnt_act [2];
    int         mcnt_act [2];

    always_comb begin
        ctrl_act[0] = {bus_a.mem_start, bus_a.freeze_if, bus_a.freeze_id, bus_a.freeze_exe,
                       bus_a.flush_ifid, bus_a.flush_idexe, bus_a.bubble_wb, bus_a.mem_timeout};
        ctrl_act[1] = {bus_b.mem_start, bus_b.freeze_if, bus_b.freeze_id, bus_b.freeze_exe,
                       bus_b.flush_ifid, bus_b.flush_idexe, bus_b.bubble_wb, bus_b.mem_timeout};
        hcnt_act[0] = int'(bus_a.hazard_cnt);
        fcnt_act[0] = int'(bus_a.flush_cnt);
        mcnt_act[0] = int'(bus_a.memwait_cnt);
        hcnt_act[1] = int'(bus_b.hazard_cnt);
        fcnt_act[1] = int'(bus_b.flush_cnt);
        mcnt_act[1] = int'(bus_b.memwait_cnt);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Behavioural model: a memory access is either outstanding (with the number
    // of cycles it has waited so far) or not. Counters are plain integers capped
    // at the maximum value of each instance.
    int model_limit [2] = '{64, 4};
    int model_max   [2] = '{65535, 3};
    bit m_busy   [2] = '{0, 0};
    int m_waited [2] = '{0, 0};
    bit m_to     [2] = '{0, 0};
    int m_h      [2] = '{0, 0};
    int m_f      [2] = '{0, 0};
    int m_m      [2] = '{0, 0};
    int cycle = 0;

    // At each falling edge, check both DUTs against the model, then update the
    // model with what the next rising edge commits.
    always @(negedge clk) begin
        if (check_en) begin
            cycle++;
            for (int i = 0; i < 2; i++) begin
                bit launch, gave_up, stall, br, hz;
                logic [7:0] exp_ctrl;
                launch  = 0;
                gave_up = 0;
                stall   = 0;
                if (!rst) begin
                    if (!m_busy[i]) begin
                        launch = mem_req && !mem_ready;
                    end else if (!mem_ready) begin
                        gave_up = (m_waited[i] == model_limit[i]);
                    end
                    stall = launch || (m_busy[i] && !mem_ready && !gave_up);
                end
                br = !rst && !stall && branch_taken;
                hz = !rst && !stall && !branch_taken && hazard;
                exp_ctrl = {launch, stall || hz, stall, stall, br, br || hz,
                            stall || gave_up, m_to[i]};
                checkOutput($sformatf("model.ctrl dut%0d cyc%0d", i, cycle), int'(ctrl_act[i]), int'(exp_ctrl));
                checkOutput($sformatf("model.hazard_cnt dut%0d cyc%0d", i, cycle), hcnt_act[i], m_h[i]);
                checkOutput($sformatf("model.flush_cnt dut%0d cyc%0d", i, cycle), fcnt_act[i], m_f[i]);
                checkOutput($sformatf("model.memwait_cnt dut%0d cyc%0d", i, cycle), mcnt_act[i], m_m[i]);
                if (rst) begin
                    m_busy[i]   = 0;
                    m_waited[i] = 0;
                    m_to[i]     = 0;
                    m_h[i]      = 0;
                    m_f[i]      = 0;
                    m_m[i]      = 0;
                end else begin
                    if (m_busy[i]) m_m[i] = (m_m[i] < model_max[i]) ? m_m[i] + 1 : m_m[i];
                    if (br) m_f[i] = (m_f[i] < model_max[i]) ? m_f[i] + 1 : m_f[i];
                    if (hz) m_h[i] = (m_h[i] < model_max[i]) ? m_h[i] + 1 : m_h[i];
                    if (launch) begin
                        m_busy[i]   = 1;
                        m_waited[i] = 1;
                    end else if (m_busy[i]) begin
                        if (mem_ready) begin
                            m_busy[i] = 0;
                        end else if (gave_up) begin
                            m_busy[i] = 0;
                            m_to[i]   = 1;
                        end else begin
                            m_waited[i]++;
                        end
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs just after a rising edge, then return after the
    // falling edge so that the caller can check that cycle's outputs.
    task automatic applyStimulus(input logic r, input logic h, input logic b,
                                 input logic q, input logic y);
        @(posedge clk);
        #1;
        rst          = r;
        hazard       = h;
        branch_taken = b;
        mem_req      = q;
        mem_ready    = y;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input high.
        applyStimulus(1, 1, 1, 1, 1);
        check_en = 1'b1;
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("rst.ctrl_a", int'(ctrl_act[0]), 0);
        checkOutput("rst.ctrl_b", int'(ctrl_act[1]), 0);
        checkOutput("rst.hazard_cnt_a", hcnt_act[0], 0);
        checkOutput("rst.memwait_cnt_a", mcnt_act[0], 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle.ctrl_a", int'(ctrl_act[0]), 0);

        // RAW hazard for three cycles.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput($sformatf("hazard.freeze_if[%0d]", k), int'(bus_a.freeze_if), 1);
            checkOutput($sformatf("hazard.flush_idexe[%0d]", k), int'(bus_a.flush_idexe), 1);
            checkOutput($sformatf("hazard.freeze_id[%0d]", k), int'(bus_a.freeze_id), 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hazard.hazard_cnt_a", hcnt_act[0], 3);
        checkOutput("hazard.hazard_cnt_b", hcnt_act[1], 3);

        // A branch and a hazard in the same cycle: the branch wins.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("branch.flush_ifid", int'(bus_a.flush_ifid), 1);
        checkOutput("branch.flush_idexe", int'(bus_a.flush_idexe), 1);
        checkOutput("branch.freeze_if", int'(bus_a.freeze_if), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("branch.flush_cnt", fcnt_act[0], 1);
        checkOutput("branch.hazard_cnt", hcnt_act[0], 0);

        // Four-cycle memory stall, then release.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("mem.c1.mem_start", int'(bus_a.mem_start), 1);
        checkOutput("mem.c1.freeze_exe", int'(bus_a.freeze_exe), 1);
        checkOutput("mem.c1.bubble_wb", int'(bus_a.bubble_wb), 1);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput($sformatf("mem.c%0d.mem_start", k), int'(bus_a.mem_start), 0);
            checkOutput($sformatf("mem.c%0d.freeze_if", k), int'(bus_a.freeze_if), 1);
            checkOutput($sformatf("mem.c%0d.bubble_wb_b", k), int'(bus_b.bubble_wb), 1);
        end
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("mem.c5.freeze_if", int'(bus_a.freeze_if), 0);
        checkOutput("mem.c5.bubble_wb", int'(bus_a.bubble_wb), 0);

        // Zero-wait access from IDLE.
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("zw.mem_start", int'(bus_a.mem_start), 0);
        checkOutput("zw.freeze_exe", int'(bus_a.freeze_exe), 0);
        checkOutput("mem.memwait_cnt_a", mcnt_act[0], 4);
        checkOutput("mem.memwait_cnt_b", mcnt_act[1], 3);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("zw.memwait_cnt_a", mcnt_act[0], 4);

        // Timeout on the short-limit instance, with a hazard on the timeout cycle.
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("to.c5.freeze_exe_b", int'(bus_b.freeze_exe), 0);
        checkOutput("to.c5.bubble_wb_b", int'(bus_b.bubble_wb), 1);
        checkOutput("to.c5.flush_idexe_b", int'(bus_b.flush_idexe), 1);
        checkOutput("to.c5.mem_timeout_b", int'(bus_b.mem_timeout), 0);
        checkOutput("to.c5.freeze_exe_a", int'(bus_a.freeze_exe), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("to.c6.mem_start_b", int'(bus_b.mem_start), 1);
        checkOutput("to.c6.mem_timeout_b", int'(bus_b.mem_timeout), 1);
        checkOutput("to.c6.hazard_cnt_b", hcnt_act[1], 1);
        checkOutput("to.c6.mem_start_a", int'(bus_a.mem_start), 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("to.rst.mem_timeout_b", int'(bus_b.mem_timeout), 0);
        checkOutput("to.rst.freeze_exe_a", int'(bus_a.freeze_exe), 0);
        checkOutput("to.rst.memwait_cnt_a", mcnt_act[0], 0);

        // The hazard counter saturates on the narrow instance.
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat.hazard_cnt_b", hcnt_act[1], 3);
        checkOutput("sat.hazard_cnt_a", hcnt_act[0], 6);

        // Mixed priorities across launch, stall, release and idle; the model checks these.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("mix.release_flush_ifid", int'(bus_a.flush_ifid), 1);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("mix.release_freeze_if", int'(bus_a.freeze_if), 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
